// File: rtl/eeprom_pkg.sv
// Shared types and constants for the I2C EEPROM responder.
package eeprom_pkg;

    typedef enum logic [3:0] {
        IDLE,
        CTRL,
        CTRL_ACK,
        WADDR,
        WADDR_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RDATA_ACK,
        IGNORE
    } state_t;

    localparam logic [3:0] DEV_ID_DEFAULT = 4'b1010;
    localparam logic       RW_WRITE       = 1'b0;
    localparam logic       RW_READ        = 1'b1;

endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA synchronizer plus edge, START and STOP detection on the system clock.
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic scl,
    input  logic sda,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_s;
    logic                   scl_d;
    logic                   sda_d;

    // Idle bus is high, so reset to 1 to avoid spurious edges after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
            scl_d    <= scl_s;
            sda_d    <= sda_s;
        end
    end

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign start_det = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

endmodule

// File: rtl/eeprom_slave.sv
// Clocked I2C EEPROM target with 2^ADDR_W x 8 storage.
// Optional write protect input WP when EEPROM_SLAVE_WP_EN is defined.
module eeprom_slave
    import eeprom_pkg::*;
#(
    parameter int         ADDR_W      = 11,
    parameter logic [3:0] DEV_ID      = DEV_ID_DEFAULT,
    parameter int         SYNC_STAGES = 2
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              SCL,
    inout  wire               SDA,
`ifdef EEPROM_SLAVE_WP_EN
    input  logic              WP,
`endif
    output logic              BUSY,
    output logic              WR_STB,
    output logic              RD_STB,
    output logic [ADDR_W-1:0] CUR_ADDR,
    output state_t            dbg_state
);

    logic sda_s, scl_rise, scl_fall, start_det, stop_det;

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (CLK),
        .rst_n     (RESET),
        .scl       (SCL),
        .sda       (SDA),
        .sda_s     (sda_s),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    logic [7:0]        mem [2**ADDR_W];
    logic [7:0]        mem_rdata;
    state_t            state, state_nxt;
    logic [3:0]        bit_cnt, bit_cnt_nxt;
    logic [7:0]        shreg, shreg_nxt;
    logic [7:0]        byte_in;
    logic              sda_oe, sda_oe_nxt;
    logic              ack_en, ack_en_nxt;
    logic              busy_nxt, rd_stb_nxt, mem_we, wr_ok;
    logic [ADDR_W-1:0] addr_nxt;

`ifdef EEPROM_SLAVE_WP_EN
    assign wr_ok = ~WP;
`else
    assign wr_ok = 1'b1;
`endif

    assign mem_rdata = mem[CUR_ADDR];
    assign byte_in   = {shreg[6:0], sda_s};
    assign SDA       = sda_oe ? 1'b0 : 1'bz;
    assign dbg_state = state;

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            shreg    <= '0;
            sda_oe   <= 1'b0;
            ack_en   <= 1'b0;
            BUSY     <= 1'b0;
            WR_STB   <= 1'b0;
            RD_STB   <= 1'b0;
            CUR_ADDR <= '0;
        end else begin
            state    <= state_nxt;
            bit_cnt  <= bit_cnt_nxt;
            shreg    <= shreg_nxt;
            sda_oe   <= sda_oe_nxt;
            ack_en   <= ack_en_nxt;
            BUSY     <= busy_nxt;
            WR_STB   <= mem_we;
            RD_STB   <= rd_stb_nxt;
            CUR_ADDR <= addr_nxt;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET && mem_we) mem[CUR_ADDR] <= byte_in;
    end

    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        shreg_nxt   = shreg;
        sda_oe_nxt  = sda_oe;
        ack_en_nxt  = ack_en;
        busy_nxt    = BUSY;
        addr_nxt    = CUR_ADDR;
        rd_stb_nxt  = 1'b0;
        mem_we      = 1'b0;
        if (start_det) begin
            state_nxt   = CTRL;
            bit_cnt_nxt = '0;
            sda_oe_nxt  = 1'b0;
            busy_nxt    = 1'b1;
        end else if (stop_det) begin
            state_nxt   = IDLE;
            bit_cnt_nxt = '0;
            sda_oe_nxt  = 1'b0;
            busy_nxt    = 1'b0;
        end else begin
            case (state)
                CTRL, WADDR, WDATA: begin
                    if (scl_rise) begin
                        shreg_nxt   = byte_in;
                        bit_cnt_nxt = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            ack_en_nxt = 1'b1;
                            if (state == CTRL) begin
                                if (byte_in[7:4] == DEV_ID) begin
                                    state_nxt = CTRL_ACK;
                                    if (byte_in[0] == RW_WRITE)
                                        addr_nxt[ADDR_W-1:8] = byte_in[ADDR_W-8:1];
                                end else begin
                                    state_nxt = IGNORE;
                                end
                            end else if (state == WADDR) begin
                                addr_nxt[7:0] = byte_in;
                                state_nxt     = WADDR_ACK;
                            end else begin
                                mem_we     = wr_ok;
                                ack_en_nxt = wr_ok;
                                addr_nxt   = CUR_ADDR + 1'b1;
                                state_nxt  = WDATA_ACK;
                            end
                        end
                    end
                end
                // bit_cnt 8: ACK not yet driven; 9: 9th rise seen, release on next fall.
                CTRL_ACK, WADDR_ACK, WDATA_ACK: begin
                    if (scl_fall && bit_cnt == 4'd8) begin
                        sda_oe_nxt = ack_en;
                    end else if (scl_rise) begin
                        bit_cnt_nxt = 4'd9;
                    end else if (scl_fall && bit_cnt == 4'd9) begin
                        sda_oe_nxt  = 1'b0;
                        bit_cnt_nxt = '0;
                        if (state == CTRL_ACK && shreg[0] == RW_READ) begin
                            state_nxt  = RDATA;
                            shreg_nxt  = mem_rdata;
                            rd_stb_nxt = 1'b1;
                            sda_oe_nxt = ~mem_rdata[7];
                        end else if (state == CTRL_ACK) begin
                            state_nxt = WADDR;
                        end else begin
                            state_nxt = WDATA;
                        end
                    end
                end
                RDATA: begin
                    if (scl_rise) begin
                        bit_cnt_nxt = bit_cnt + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt == 4'd8) begin
                            sda_oe_nxt = 1'b0;
                            addr_nxt   = CUR_ADDR + 1'b1;
                            state_nxt  = RDATA_ACK;
                        end else begin
                            sda_oe_nxt = ~shreg[~bit_cnt[2:0]];
                        end
                    end
                end
                RDATA_ACK: begin
                    if (scl_rise) begin
                        bit_cnt_nxt = '0;
                        if (!sda_s) begin
                            state_nxt  = RDATA;
                            shreg_nxt  = mem_rdata;
                            rd_stb_nxt = 1'b1;
                        end else begin
                            state_nxt = IGNORE;
                        end
                    end
                end
                IDLE, IGNORE: ;
                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule
